// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds in-flight predictions in program order with their
// global history snapshot, and turns each in-order resolution into a one-cycle
// predictor training update. A mispredict squashes every younger entry and
// raises a one-cycle flush toward fetch.
module branch_resolve_queue #(
  parameter int DEPTH  = 8,
  parameter int HIST_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic                     pred_taken,
  input  logic [HIST_W-1:0]        pred_hist,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_valid,
  output logic                     upd_taken,
  output logic [HIST_W-1:0]        upd_hist,
  output logic                     upd_mispredict,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         mispredict_count,
  output logic                     underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic              taken;
    logic [HIST_W-1:0] hist;
  } entry_t;

  // FLUSH is the single cycle after a mispredicting pop; fetch is held off.
  typedef enum logic {RUN, FLUSH} state_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PW:0]        occ_q, occ_d;
  state_t             state_q, state_d;
  logic               upd_valid_q, upd_valid_d;
  logic               upd_taken_q, upd_taken_d;
  logic [HIST_W-1:0]  upd_hist_q, upd_hist_d;
  logic               upd_mis_q, upd_mis_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
  logic               uflow_q, uflow_d;

  logic full, push, pop, mis;
  entry_t head_e;

  // Occupancy alone tells full from empty; head==tail is ambiguous.
  assign full       = (occ_q == OCC_FULL);
  assign pred_ready = !full && (state_q == RUN) && !reset;
  assign push       = pred_valid && pred_ready;
  assign pop        = resolve_valid && (occ_q != '0);
  assign head_e     = mem_q[head_q];
  assign mis        = pop && (head_e.taken != resolve_taken);

  // Next-state: pointers, storage, update outputs and statistics.
  always_comb begin
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    state_d     = mis ? FLUSH : RUN;
    upd_valid_d = pop;
    upd_taken_d = upd_taken_q;
    upd_hist_d  = upd_hist_q;
    upd_mis_d   = upd_mis_q;
    mis_cnt_d   = mis_cnt_q;
    uflow_d     = uflow_q || (resolve_valid && (occ_q == '0));

    if (pop) begin
      head_d      = head_q + PW'(1);
      upd_taken_d = resolve_taken;
      upd_hist_d  = head_e.hist;
      upd_mis_d   = mis;
    end

    if (mis) begin
      // Everything younger than the mispredicted branch is wrong-path,
      // including a prediction offered on this same edge.
      tail_d = head_q + PW'(1);
      occ_d  = '0;
      if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end else begin
      if (push) begin
        mem_d[tail_q] = '{taken: pred_taken, hist: pred_hist};
        tail_d        = tail_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + (PW+1)'(1);
        2'b01:   occ_d = occ_q - (PW+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      state_q     <= RUN;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      upd_hist_q  <= '0;
      upd_mis_q   <= 1'b0;
      mis_cnt_q   <= '0;
      uflow_q     <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      state_q     <= state_d;
      upd_valid_q <= upd_valid_d;
      upd_taken_q <= upd_taken_d;
      upd_hist_q  <= upd_hist_d;
      upd_mis_q   <= upd_mis_d;
      mis_cnt_q   <= mis_cnt_d;
      uflow_q     <= uflow_d;
    end
  end

  assign upd_valid        = upd_valid_q;
  assign upd_taken        = upd_taken_q;
  assign upd_hist         = upd_hist_q;
  assign upd_mispredict   = upd_mis_q;
  assign flush            = (state_q == FLUSH);
  assign occupancy        = occ_q;
  assign mispredict_count = mis_cnt_q;
  assign underflow_err    = uflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a queue-based reference model is
// compared against the DUT every cycle, plus literal spot checks per scenario.
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int HW    = 12;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pred_valid = 1'b0, pred_taken = 1'b0;
  logic [HW-1:0] pred_hist = '0;
  logic          resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic          pred_ready, upd_valid, upd_taken, upd_mispredict, flush, underflow_err;
  logic [HW-1:0] upd_hist;
  logic [3:0]    occupancy;
  logic [CW-1:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_queue #(.DEPTH(DEPTH), .HIST_W(HW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_taken(pred_taken), .pred_hist(pred_hist),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_hist(upd_hist),
    .upd_mispredict(upd_mispredict), .flush(flush), .occupancy(occupancy),
    .mispredict_count(mispredict_count), .underflow_err(underflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-flight branches as an ordered list.
  typedef struct { logic t; logic [HW-1:0] h; } ent_t;
  ent_t          mq[$];
  logic          m_uv = 0, m_ut = 0, m_um = 0, m_fl = 0, m_uf = 0;
  logic [HW-1:0] m_uh = '0;
  int            m_cnt = 0;

  function automatic logic m_ready();
    return !reset && (mq.size() < DEPTH) && !m_fl;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_uv = 0; m_ut = 0; m_um = 0; m_fl = 0; m_uf = 0; m_uh = '0; m_cnt = 0;
    end else begin
      automatic logic acc = pred_valid && m_ready();
      automatic logic wrong = 1'b0;
      automatic ent_t e;
      m_uv = 1'b0;
      if (resolve_valid && mq.size() == 0) m_uf = 1'b1;
      if (resolve_valid && mq.size() != 0) begin
        e = mq.pop_front();
        wrong = (e.t != resolve_taken);
        m_uv = 1'b1; m_ut = resolve_taken; m_uh = e.h; m_um = wrong;
        if (wrong) begin
          mq.delete();
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end
      if (acc && !wrong) mq.push_back('{t: pred_taken, h: pred_hist});
      m_fl = wrong;
    end
  end

  // Every-cycle comparison, sampled just after the active edge.
  always @(posedge clock) begin
    #1;
    chk("m.pred_ready", 32'(pred_ready), 32'(m_ready()));
    chk("m.upd_valid", 32'(upd_valid), 32'(m_uv));
    chk("m.upd_taken", 32'(upd_taken), 32'(m_ut));
    chk("m.upd_hist", 32'(upd_hist), 32'(m_uh));
    chk("m.upd_mispredict", 32'(upd_mispredict), 32'(m_um));
    chk("m.flush", 32'(flush), 32'(m_fl));
    chk("m.occupancy", 32'(occupancy), 32'(mq.size()));
    chk("m.mispredict_count", 32'(mispredict_count), 32'(m_cnt));
    chk("m.underflow_err", 32'(underflow_err), 32'(m_uf));
  end

  // Present inputs for one edge; returns at the following negedge.
  task automatic cyc(input logic pv, input logic pt, input logic [HW-1:0] ph,
                     input logic rv, input logic rt);
    pred_valid = pv; pred_taken = pt; pred_hist = ph;
    resolve_valid = rv; resolve_taken = rt;
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset.pred_ready", 32'(pred_ready), 0);
    chk("reset.occupancy", 32'(occupancy), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset.pred_ready", 32'(pred_ready), 1);

    // In-order correct resolutions.
    cyc(1, 1, 12'h001, 0, 0);
    cyc(1, 0, 12'h002, 0, 0);
    cyc(1, 1, 12'h003, 0, 0);
    chk("t1.occ3", 32'(occupancy), 3);
    cyc(0, 0, '0, 1, 1);
    chk("t1.uv1", 32'(upd_valid), 1);
    chk("t1.hist1", 32'(upd_hist), 12'h001);
    cyc(0, 0, '0, 1, 0);
    chk("t1.hist2", 32'(upd_hist), 12'h002);
    chk("t1.mis2", 32'(upd_mispredict), 0);
    cyc(0, 0, '0, 1, 1);
    chk("t1.hist3", 32'(upd_hist), 12'h003);
    idle();
    chk("t1.occ0", 32'(occupancy), 0);
    chk("t1.hold_hist", 32'(upd_hist), 12'h003);
    chk("t1.uv0", 32'(upd_valid), 0);

    // Fill, blocked enqueue, pop while full, wrap.
    for (int i = 0; i < DEPTH; i++) cyc(1, i[0], HW'(12'h010 + i), 0, 0);
    chk("t2.full_occ", 32'(occupancy), 8);
    chk("t2.full_ready", 32'(pred_ready), 0);
    cyc(1, 1, 12'h0AA, 0, 0);
    chk("t2.no_store", 32'(occupancy), 8);
    cyc(1, 1, 12'h0AB, 1, 0);
    chk("t2.pop_occ", 32'(occupancy), 7);
    chk("t2.pop_ready", 32'(pred_ready), 1);
    chk("t2.pop_hist", 32'(upd_hist), 12'h010);
    cyc(1, 1, 12'h0AC, 0, 0);
    chk("t2.wrap_occ", 32'(occupancy), 8);
    for (int i = 1; i < DEPTH; i++) cyc(0, 0, '0, 1, i[0]);
    cyc(0, 0, '0, 1, 1);
    chk("t2.wrap_hist", 32'(upd_hist), 12'h0AC);
    chk("t2.wrap_mis", 32'(upd_mispredict), 0);
    idle();

    // Mispredict with a concurrent enqueue.
    for (int i = 0; i < 4; i++) cyc(1, 1, HW'(12'h100 + i), 0, 0);
    cyc(1, 1, 12'h1FF, 1, 0);
    chk("t3.mis", 32'(upd_mispredict), 1);
    chk("t3.flush", 32'(flush), 1);
    chk("t3.occ", 32'(occupancy), 0);
    chk("t3.cnt", 32'(mispredict_count), 1);
    chk("t3.ready", 32'(pred_ready), 0);
    chk("t3.hist", 32'(upd_hist), 12'h100);
    idle();
    chk("t3.flush_gone", 32'(flush), 0);
    chk("t3.occ_after", 32'(occupancy), 0);

    // Empty resolve.
    cyc(0, 0, '0, 1, 1);
    chk("t4.uv", 32'(upd_valid), 0);
    chk("t4.uflow", 32'(underflow_err), 1);
    cyc(1, 0, 12'h200, 0, 0);
    cyc(0, 0, '0, 1, 0);
    idle();
    chk("t4.sticky", 32'(underflow_err), 1);

    // Asynchronous reset mid-stream with an update pending.
    for (int i = 0; i < 5; i++) cyc(1, 0, HW'(12'h300 + i), 0, 0);
    cyc(0, 0, '0, 1, 0);
    chk("t5.pending", 32'(upd_valid), 1);
    pred_valid = 0; resolve_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("t5.uv", 32'(upd_valid), 0);
    chk("t5.hist", 32'(upd_hist), 0);
    chk("t5.occ", 32'(occupancy), 0);
    chk("t5.ready", 32'(pred_ready), 0);
    chk("t5.uflow", 32'(underflow_err), 0);
    chk("t5.cnt", 32'(mispredict_count), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t5.occ_rel", 32'(occupancy), 0);
    chk("t5.ready_rel", 32'(pred_ready), 1);

    // Counter saturation: 19 mispredicts on a 4-bit counter.
    for (int i = 0; i < 19; i++) begin
      cyc(1, 1, HW'(i), 0, 0);
      cyc(0, 0, '0, 1, 0);
      idle();
      if (i == 14) chk("t6.cnt15", 32'(mispredict_count), 15);
    end
    chk("t6.sat", 32'(mispredict_count), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Resolution-side companion to the global 2-bit predictor FSM.
- Buffers each prediction issued at fetch, in program order, together with the global history it used.
- When execute resolves the oldest in-flight branch, compares actual against predicted and emits a one-cycle training update (actual outcome drives the predictor's BranchTaken).
- On a mispredict it also emits a flush and discards all younger entries.

Parameters:
DEPTH, 8, number of in-flight branch entries; power of two, >= 2
HIST_W, 12, width of the global history snapshot stored per entry
CNT_W, 16, width of the saturating mispredict statistics counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
pred_valid  input  1  fetch presents a new prediction
pred_ready  output  1  queue accepts a prediction this cycle
pred_taken  input  1  predicted direction (1 = taken)
pred_hist  input  HIST_W  global history used for the prediction
resolve_valid  input  1  execute resolves the oldest in-flight branch
resolve_taken  input  1  actual direction
upd_valid  output  1  training update valid (one-cycle pulse)
upd_taken  output  1  actual outcome, drives predictor BranchTaken
upd_hist  output  HIST_W  history snapshot of the resolved branch
upd_mispredict  output  1  predicted != actual for this update
flush  output  1  one-cycle pulse; redirect fetch, younger entries gone
occupancy  output  $clog2(DEPTH)+1  current entry count
mispredict_count  output  CNT_W  saturating count of mispredicts
underflow_err  output  1  sticky: resolve_valid seen with queue empty

Behaviour:
- Reset (async, active-high, any time, including mid-operation): pointers 0, occupancy 0, all entries invalid; upd_valid, upd_taken, upd_hist, upd_mispredict, flush, mispredict_count, underflow_err = 0. pred_ready = 0 while reset is asserted.
- Storage: circular buffer of DEPTH entries {pred_taken, pred_hist}. Head = oldest entry; tail = next free slot. Pointers wrap modulo DEPTH.
- Enqueue:
  - pred_ready = !full && !flush && !reset (combinational from registered state).
  - An entry is written at tail on a clock edge where pred_valid && pred_ready.
  - No write-through when full, even if a resolve occurs in the same cycle.
- Resolve:
  - On an edge with resolve_valid && occupancy != 0, the head entry is popped.
  - Registered outputs in the next cycle (latency 1): upd_valid=1, upd_taken=resolve_taken, upd_hist=head.hist, upd_mispredict=(head.taken != resolve_taken).
  - upd_* hold their last values when upd_valid=0; only upd_valid and flush are pulses.
- Mispredict:
  - On the same edge as the pop, tail is set to the new head and occupancy becomes 0. Any enqueue accepted in that same cycle is dropped.
  - flush=1 in the next cycle, aligned with upd_valid. pred_ready=0 during the flush cycle.
  - mispredict_count increments and saturates at all-ones.
- Simultaneous enqueue + correct resolve: both occur; occupancy is unchanged.
- Empty resolve: resolve_valid with occupancy 0 is ignored (no update, no flush) and sets underflow_err=1. underflow_err is cleared only by reset.
- Two state-like conditions, derived from registered signals:
  - RUN: normal operation.
  - FLUSH: single cycle following a mispredicting pop. Always returns to RUN.
- Occupancy reaches DEPTH exactly when full; full/empty are distinguished by occupancy, not by pointer equality.

Test Plan:
- Reset then enqueue 3 entries (T/hist 0x001, N/0x002, T/0x003), resolve T,N,T -> three upd_valid pulses, one cycle after each resolve, hist 0x001/0x002/0x003; upd_mispredict=0, flush never set, occupancy returns to 0.
- Fill to DEPTH=8 -> pred_ready=0, occupancy=8. A further pred_valid is not stored. Resolve one correctly while pred_valid is held -> pred_ready=1 next cycle, tail wraps to slot 0.
- Enqueue 4 entries, head predicted T, resolve N -> next cycle upd_mispredict=1, flush=1, occupancy=0, mispredict_count=1, pred_ready=0 that cycle. A concurrent enqueue is absent from the queue.
- Resolve_valid on empty queue -> no upd_valid, underflow_err=1 and stays 1 through later normal traffic until reset.
- Assert reset mid-stream with 5 entries and a pending update -> all outputs 0 immediately (asynchronously); after release, occupancy=0 and pred_ready=1.
- Force 2^CNT_W+3 mispredicts (CNT_W overridden to 4: 19 mispredicts) -> mispredict_count saturates at 15.
